// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and helpers: transfer/size/state encodings, response
// constants, error classification and little-endian byte-strobe generation.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slave_state_e;

  // Out of range, oversized, or not naturally aligned for its size.
  function automatic logic xfer_error(input logic [31:0] addr,
                                      input logic [2:0]  size,
                                      input logic [31:0] limit);
    logic e;
    e = (addr >= limit) || (size > 3'd2) ||
        ((size == 3'd1) && addr[0]) ||
        ((size == 3'd2) && (addr[1:0] != 2'b00));
    return e;
  endfunction

  function automatic logic [3:0] byte_strobe(input logic [2:0] size,
                                             input logic [1:0] off);
    logic [3:0] s;
    case (hsize_e'(size))
      SIZE_BYTE: s = 4'b0001 << off;
      SIZE_HALF: s = 4'b0011 << off;
      default:   s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// Word-organised SRAM bank: per-byte write enable, asynchronous word read.
module ahb_sram_bank #(
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] merged;

  assign rdata_o = mem_q[addr_i];

  // Read-modify-write merge so partial writes keep the untouched lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged[gi*8 +: 8] = we_i[gi] ? wdata_i[gi*8 +: 8] : rdata_o[gi*8 +: 8];
  end

  always_ff @(posedge clk_i) begin
    if (|we_i) begin
      mem_q[addr_i] <= merged;
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: address/data phase pipeline, OKAY/ERROR response FSM.
// Optional NONSEQ wait states are compiled in with AHB_SLAVE_WAIT_EN.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  slave_state_e  state_q, state_d;
  logic [1:0]    trans_q, trans_d;
  logic [AW-1:0] word_q, word_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    size_q, size_d;
  logic          write_q, write_d;
  logic          err_q, err_d;

  logic          accept;
  logic          addr_err;
  logic          wait_req;
  logic          dp_active;
  logic [3:0]    bank_we;
  logic [31:0]   bank_rdata;

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign addr_err  = xfer_error(HADDR, HSIZE, ADDR_LIMIT);
  assign dp_active = trans_q[1];

`ifdef AHB_SLAVE_WAIT_EN
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign wait_req = (HTRANS == TRANS_NONSEQ) && (WAIT_CYCLES > 0);
`else
  assign wait_req = 1'b0;
`endif

  // Address-phase capture happens only when the bus advances.
  always_comb begin
    trans_d = trans_q;
    word_d  = word_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    err_d   = err_q;
    if (HREADY) begin
      trans_d = accept ? HTRANS : TRANS_IDLE;
      err_d   = accept & addr_err;
      if (accept) begin
        word_d  = HADDR[AW+1:2];
        off_d   = HADDR[1:0];
        size_d  = HSIZE;
        write_d = HWRITE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef AHB_SLAVE_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept && addr_err) begin
          state_d = ST_ERR1;
        end else if (accept && wait_req) begin
          state_d = ST_WAIT;
`ifdef AHB_SLAVE_WAIT_EN
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
`endif
        end
      end
      ST_WAIT: begin
`ifdef AHB_SLAVE_WAIT_EN
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      trans_q <= TRANS_IDLE;
      word_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef AHB_SLAVE_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      trans_q <= trans_d;
      word_q  <= word_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
      err_q   <= err_d;
`ifdef AHB_SLAVE_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state_q)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  // The IDLE state with a live data phase is the final, OKAY cycle of a transfer.
  assign bank_we = (!HRESET && state_q == ST_IDLE && dp_active && write_q && !err_q)
                   ? byte_strobe(size_q, off_q) : 4'b0000;

  assign HRDATA = (dp_active && !write_q && !err_q) ? bank_rdata : 32'h0;

  ahb_sram_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk_i   (HCLK),
    .we_i    (bank_we),
    .addr_i  (word_q),
    .wdata_i (HWDATA),
    .rdata_o (bank_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed self-checking bench for ahb_sram_slave with a pipelined master model.
module tb_ahb_sram_slave;
  localparam int DEPTH = 256;
  localparam int WC    = 1;
`ifdef AHB_SLAVE_WAIT_EN
  localparam int WS = WC;
`else
  localparam int WS = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  int total = 0;
  int bad   = 0;

  bit          pend_valid = 1'b0;
  bit          pend_write;
  bit          pend_err;
  int          pend_wait;
  logic [31:0] pend_wdata = 32'h0;
  logic [31:0] pend_exp;
  string       pend_tag;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs the pending data phase to completion, checking stalls, response and read data.
  task automatic finish_dp();
    int waits;
    logic first_resp;
    waits = 0;
    first_resp = 1'b0;
    forever begin
      @(negedge HCLK);
      if (HREADYOUT) break;
      if (waits == 0) first_resp = HRESP;
      waits++;
      if (waits > 40) begin
        chk({pend_tag, "_timeout"}, 32'(waits), 32'(pend_wait));
        break;
      end
      @(posedge HCLK); #1;
    end
    if (pend_valid) begin
      chk({pend_tag, "_waits"}, 32'(waits), 32'(pend_wait));
      chk({pend_tag, "_resp"}, {31'b0, HRESP}, {31'b0, pend_err});
      if (pend_err) chk({pend_tag, "_resp1"}, {31'b0, first_resp}, 32'd1);
      if (!pend_write && !pend_err) chk({pend_tag, "_rdata"}, HRDATA, pend_exp);
      $display("txn %s waits=%0d resp=%0d rdata=%h", pend_tag, waits, HRESP, HRDATA);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic beat(input logic [1:0] tr, input logic [31:0] addr, input logic [2:0] sz,
                      input bit wr, input logic [31:0] wdata, input logic [31:0] exp,
                      input bit err, input string tag);
    HSEL   = 1'b1;
    HTRANS = tr;
    HADDR  = addr;
    HSIZE  = sz;
    HWRITE = wr;
    HWDATA = pend_wdata;
    finish_dp();
    pend_valid = tr[1];
    pend_write = wr;
    pend_err   = err;
    pend_wait  = err ? 1 : ((tr == 2'd2) ? WS : 0);
    pend_wdata = wdata;
    pend_exp   = exp;
    pend_tag   = tag;
  endtask

  task automatic idle();
    beat(2'd0, 32'h0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, "idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd2;
    HTRANS = 2'd0; HBURST = '0; HPROT = '0; HMASTLOCK = 1'b0; HWDATA = '0;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_readyout", {31'b0, HREADYOUT}, 32'd1);
    chk("rst_resp", {31'b0, HRESP}, 32'd0);
    chk("rst_rdata", HRDATA, 32'h0);
    @(posedge HCLK); #1;

    // Word write then read, back to back
    beat(2'd2, 32'h4, 3'd2, 1'b1, 32'hAABB_CCDD, 32'h0, 1'b0, "wr4");
    beat(2'd2, 32'h4, 3'd2, 1'b0, 32'h0, 32'hAABB_CCDD, 1'b0, "rd4");
    idle();

    // Byte and halfword lanes
    beat(2'd2, 32'h8, 3'd2, 1'b1, 32'h0, 32'h0, 1'b0, "wr8");
    beat(2'd2, 32'h9, 3'd0, 1'b1, 32'h0000_1100, 32'h0, 1'b0, "wrb9");
    beat(2'd2, 32'hA, 3'd1, 1'b1, 32'hBEEF_0000, 32'h0, 1'b0, "wrhA");
    beat(2'd2, 32'h8, 3'd2, 1'b0, 32'h0, 32'hBEEF_1100, 1'b0, "rd8");
    beat(2'd2, 32'hB, 3'd0, 1'b1, 32'h7700_0000, 32'h0, 1'b0, "wrbB");
    beat(2'd2, 32'h8, 3'd2, 1'b0, 32'h0, 32'h77EF_1100, 1'b0, "rd8b");
    idle();

    // Pipelined write then read of same word
    beat(2'd2, 32'h10, 3'd2, 1'b1, 32'h1234_5678, 32'h0, 1'b0, "wr10");
    beat(2'd2, 32'h10, 3'd2, 1'b0, 32'h0, 32'h1234_5678, 1'b0, "rd10");

    // SEQ burst write and read back
    beat(2'd2, 32'h20, 3'd2, 1'b1, 32'hA0A0_0000, 32'h0, 1'b0, "bw20");
    beat(2'd3, 32'h24, 3'd2, 1'b1, 32'hA1A1_1111, 32'h0, 1'b0, "bw24");
    beat(2'd3, 32'h28, 3'd2, 1'b1, 32'hA2A2_2222, 32'h0, 1'b0, "bw28");
    beat(2'd3, 32'h2C, 3'd2, 1'b1, 32'hA3A3_3333, 32'h0, 1'b0, "bw2C");
    beat(2'd2, 32'h20, 3'd2, 1'b0, 32'h0, 32'hA0A0_0000, 1'b0, "br20");
    beat(2'd3, 32'h24, 3'd2, 1'b0, 32'h0, 32'hA1A1_1111, 1'b0, "br24");
    beat(2'd3, 32'h28, 3'd2, 1'b0, 32'h0, 32'hA2A2_2222, 1'b0, "br28");
    beat(2'd3, 32'h2C, 3'd2, 1'b0, 32'h0, 32'hA3A3_3333, 1'b0, "br2C");
    idle();

    // Top legal word
    beat(2'd2, 32'h3FC, 3'd2, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0, "wr3FC");
    beat(2'd2, 32'h3FC, 3'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, "rd3FC");

    // Error responses; master drives IDLE in the ERR2 cycle
    beat(2'd2, 32'h0, 3'd2, 1'b1, 32'h5A5A_1234, 32'h0, 1'b0, "wr0");
    beat(2'd2, 32'h2, 3'd2, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, "err_mis");
    idle();
    beat(2'd2, 32'h400, 3'd2, 1'b0, 32'h0, 32'h0, 1'b1, "err_oor");
    idle();
    beat(2'd2, 32'h1, 3'd1, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, "err_half");
    idle();
    beat(2'd2, 32'h0, 3'd3, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, "err_size");
    idle();
    beat(2'd2, 32'h0, 3'd2, 1'b0, 32'h0, 32'h5A5A_1234, 1'b0, "rd0");
    beat(2'd2, 32'h3FC, 3'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, "rd3FCb");
    idle();

    // Reset during a write data phase discards the write
    beat(2'd2, 32'h30, 3'd2, 1'b1, 32'h1111_1111, 32'h0, 1'b0, "wr30");
    idle();
    beat(2'd2, 32'h30, 3'd2, 1'b1, 32'h2222_2222, 32'h0, 1'b0, "wr30x");
    HTRANS = 2'd0;
    HWDATA = 32'h2222_2222;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    pend_valid = 1'b0;
    pend_wdata = 32'h0;
    @(negedge HCLK);
    chk("mrst_readyout", {31'b0, HREADYOUT}, 32'd1);
    chk("mrst_resp", {31'b0, HRESP}, 32'd0);
    chk("mrst_rdata", HRDATA, 32'h0);
    @(posedge HCLK); #1;
    beat(2'd2, 32'h30, 3'd2, 1'b0, 32'h0, 32'h1111_1111, 1'b0, "rd30");
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
